mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, memory byte-address width.
REQ-002 Parameter MEM_W, default 8, memory data width.
REQ-003 Parameter WORD_W, default 32, pipeline word width (= 4*MEM_W).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low. Ports, clock and reset first:
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  pipeline access request.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_write  in  1  1=store, 0=load.
REQ-010 req_size  in  1  0=byte, 1=word.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  WORD_W  store data; byte store uses [7:0].
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  WORD_W  load result.
REQ-015 resp_err  out  1  misaligned word access; valid with resp_valid.
REQ-016 mem_enable  out  1  to memory Enable.
REQ-017 mem_readwrite  out  1  to memory ReadWrite (1=read, 0=write).
REQ-018 mem_address  out  ADDR_W  to memory Address.
REQ-019 mem_datain  out  MEM_W  to memory DataIn.
REQ-020 mem_dataout  in  MEM_W  from memory DataOut.

Function
REQ-021 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; req_ready=1 only in IDLE.
REQ-022 Acceptance SHALL occur on a rising edge with req_valid=1 in IDLE; write, size, addr and wdata SHALL be captured then, and later changes SHALL be ignored.
REQ-023 Word access with req_addr[1:0]!=0 SHALL go IDLE->DONE with resp_err=1, no memory access, and resp_rdata unchanged.
REQ-024 Valid accesses SHALL go IDLE->SETUP; byte count 1 (byte) or 4 (word), 2-bit index starting at 0.
REQ-025 SETUP: drive mem_address = base+index, mem_readwrite, mem_datain, with mem_enable=0; next state ACCESS.
REQ-026 ACCESS: mem_enable=1 with address, data and readwrite held stable; for loads, mem_dataout SHALL be sampled at the end of the ACCESS cycle.
REQ-027 After ACCESS, the block SHALL go to SETUP for the next byte, or to DONE after the last byte; mem_enable SHALL therefore fall between bytes so every access produces an enable edge.
REQ-028 Byte order SHALL be big-endian: byte at base+0 = word[31:24], base+3 = word[7:0].
REQ-029 Byte load SHALL zero-extend into resp_rdata[31:8].
REQ-030 Store completion SHALL drive resp_rdata=0.
REQ-031 DONE SHALL assert resp_valid for exactly one cycle and then go to IDLE.
REQ-032 resp_rdata SHALL hold its value until the next resp_valid.
REQ-033 Latency (acceptance edge to resp_valid cycle) SHALL be 9 cycles for a word, 3 for a byte, and 1 for a misaligned access.
REQ-034 Outside SETUP/ACCESS, the block SHALL drive mem_enable=0 and mem_readwrite=1; mem_datain SHALL be 0 except during store SETUP/ACCESS.
REQ-035 Address arithmetic SHALL be modulo 2^ADDR_W; a byte access at 1023 is legal.
REQ-036 A new request MAY be accepted in the cycle after DONE; no back-to-back overlap.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, index 0, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_enable=0, mem_readwrite=1, mem_address=0, mem_datain=0.
REQ-038 Reset mid-access SHALL abort the access without a response, and any partial load data SHALL be discarded.

Structure
REQ-039 Shared package mem_access_pkg SHALL hold the state enum, ADDR_W/MEM_W/WORD_W defaults, and SIZE_BYTE/SIZE_WORD and RW_READ/RW_WRITE constants.
REQ-040 Single module; no sub-module is required, and the byte assembly shift register is inline.

Verification
REQ-041 Word store 0xDEADBEEF at addr 0x010 -> mem writes DE,AD,BE,EF at 0x010..0x013, each with an enable rising edge and readwrite=0; resp_valid 9 cycles after acceptance; resp_err=0.
REQ-042 Word load from 0x010 after REQ-041 -> resp_rdata=0xDEADBEEF.
REQ-043 Byte store 0x5A at 0x3FF, then byte load 0x3FF -> resp_rdata=0x0000005A, latency 3.
REQ-044 Word load at 0x013 -> resp_err=1 on the next cycle; mem_enable never asserted; resp_rdata unchanged.
REQ-045 rst_n low during ACCESS of byte 2 of a word load -> mem_enable=0 and req_ready=1 immediately; no resp_valid; the following load succeeds.
REQ-046 req_valid held high while busy with changing req_addr -> only the first request is executed; req_ready=0 until after DONE.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared types and constants for the byte-wide memory access block.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

   localparam int ADDR_W_DEFAULT = 10;
   localparam int MEM_W_DEFAULT  = 8;
   localparam int WORD_W_DEFAULT = 4 * MEM_W_DEFAULT;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;
   localparam logic RW_READ   = 1'b1;
   localparam logic RW_WRITE  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Brief    : Pipeline request/response bus plus byte-wide memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int MEM_W  = MEM_W_DEFAULT,
   parameter int WORD_W = WORD_W_DEFAULT
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              resp_valid;
   logic [WORD_W-1:0] resp_rdata;
   logic              resp_err;
   logic              mem_enable;
   logic              mem_readwrite;
   logic [ADDR_W-1:0] mem_address;
   logic [MEM_W-1:0]  mem_datain;
   logic [MEM_W-1:0]  mem_dataout;

   modport slave (
      input  req_valid, req_write, req_size, req_addr, req_wdata, mem_dataout,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_enable, mem_readwrite, mem_address, mem_datain
   );

   modport master (
      output req_valid, req_write, req_size, req_addr, req_wdata, mem_dataout,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_enable, mem_readwrite, mem_address, mem_datain
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Splits 32-bit pipeline loads/stores into big-endian byte accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int MEM_W  = MEM_W_DEFAULT,
   parameter int WORD_W = 4 * MEM_W
)(
   input  wire logic clk,
   input  wire logic rst_n,
   mem_access_ctrl_if.slave bus
);

   state_t            r_state;
   state_t            w_next;
   logic              r_write;
   logic              r_err;
   logic [1:0]        r_idx;
   logic [1:0]        r_last;
   logic [ADDR_W-1:0] r_base;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] r_rdata;
   logic              w_accept;
   logic              w_misaligned;
   logic              w_last_byte;
   logic              w_busy;
   logic [WORD_W-1:0] w_shift_in;

   assign w_accept     = (r_state == ST_IDLE) && bus.req_valid;
   assign w_misaligned = (bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00);
   assign w_last_byte  = (r_idx == r_last);
   assign w_busy       = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
   assign w_shift_in   = {r_shift[WORD_W-MEM_W-1:0], bus.mem_dataout};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_accept) w_next = w_misaligned ? ST_DONE : ST_SETUP;
         ST_SETUP:  w_next = ST_ACCESS;
         ST_ACCESS: w_next = w_last_byte ? ST_DONE : ST_SETUP;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // One shift register serves both directions: stores shift data out of the
   // top byte, loads shift memory bytes in from the bottom (big-endian order).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= 2'd0;
         r_last  <= 2'd0;
         r_base  <= '0;
         r_shift <= '0;
         r_rdata <= '0;
      end else if (w_accept) begin
         r_write <= bus.req_write;
         r_err   <= w_misaligned;
         r_idx   <= 2'd0;
         r_last  <= (bus.req_size == SIZE_WORD) ? 2'd3 : 2'd0;
         r_base  <= bus.req_addr;
         if (!bus.req_write) begin
            r_shift <= '0;
         end else if (bus.req_size == SIZE_WORD) begin
            r_shift <= bus.req_wdata;
         end else begin
            r_shift <= {bus.req_wdata[MEM_W-1:0], {(WORD_W-MEM_W){1'b0}}};
         end
      end else if (r_state == ST_ACCESS) begin
         r_shift <= w_shift_in;
         r_idx   <= r_idx + 2'd1;
         if (w_last_byte) begin
            r_rdata <= r_write ? '0 : w_shift_in;
         end
      end
   end

   always_comb begin
      bus.req_ready     = (r_state == ST_IDLE);
      bus.resp_valid    = (r_state == ST_DONE);
      bus.resp_err      = (r_state == ST_DONE) && r_err;
      bus.resp_rdata    = r_rdata;
      bus.mem_enable    = (r_state == ST_ACCESS);
      bus.mem_readwrite = RW_READ;
      bus.mem_address   = '0;
      bus.mem_datain    = '0;
      if (w_busy) begin
         bus.mem_address = r_base + ADDR_W'(r_idx);
         if (r_write) begin
            bus.mem_readwrite = RW_WRITE;
            bus.mem_datain    = r_shift[WORD_W-1 -: MEM_W];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Scoreboard bench with a behavioural byte memory for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   int   n_en_rise = 0;
   logic en_q     = 1'b0;
   logic mem_init = 1'b0;
   logic [7:0]  mem [0:1023];
   logic [17:0] wlog [$];
   exp_t        sb [$];
   exp_t        e_mon;
   logic [31:0] last_rdata = 32'h0;

   mem_access_ctrl_if bus ();

   mem_access_ctrl u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_dataout = mem[bus.mem_address];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory model: writes on an enable rising edge, asynchronous read.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem[10'h3FC] <= 8'h11;
         mem[10'h3FD] <= 8'h22;
         mem[10'h3FE] <= 8'h33;
         mem_init <= 1'b1;
      end else if (bus.mem_enable && !en_q) begin
         n_en_rise = n_en_rise + 1;
         if (bus.mem_readwrite == 1'b0) begin
            mem[bus.mem_address] <= bus.mem_datain;
            wlog.push_back({bus.mem_address, bus.mem_datain});
         end
      end
      en_q <= bus.mem_enable;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req_ready)
            check("idle_bus", {bus.mem_enable, bus.mem_readwrite, bus.mem_datain}, {1'b0, 1'b1, 8'h00});
         if (bus.mem_enable && bus.mem_readwrite)
            check("load_datain", bus.mem_datain, 8'h00);
         if (bus.resp_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_resp", 1, 0);
            end else begin
               e_mon = sb.pop_front();
               check("rdata", bus.resp_rdata, e_mon.rdata);
               check("err", bus.resp_err, e_mon.err);
               check("latency", cyc - acc_cyc + 1, e_mon.lat);
            end
         end
      end
   end

   task automatic issue(input logic w, input logic s, input logic [9:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat);
      exp_t e;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_size  = s;
      bus.req_addr  = a;
      bus.req_wdata = d;
      e.rdata = exp_err ? last_rdata : exp_rd;
      e.err   = exp_err;
      e.lat   = lat;
      last_rdata = e.rdata;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom_range(0, 1023);
      bus.req_wdata = $urandom;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sb.size() != 0 && k < 40) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (sb.size() != 0) begin
         check("resp_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   initial begin
      logic [31:0] word;
      int          e0;
      logic        found;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_size  = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", bus.req_ready, 1);
      check("rst_valid", bus.resp_valid, 0);
      check("rst_err", bus.resp_err, 0);
      check("rst_rdata", bus.resp_rdata, 0);
      check("rst_enable", bus.mem_enable, 0);
      check("rst_rw", bus.mem_readwrite, 1);
      check("rst_addr", bus.mem_address, 0);
      check("rst_datain", bus.mem_datain, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Word store, then check the four big-endian byte writes
      word = 32'hDEADBEEF;
      wlog.delete();
      issue(1'b1, 1'b1, 10'h010, word, 32'h0, 1'b0, 9);
      wait_idle();
      check("ws_nwrites", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++)
         check("ws_byte", wlog[i], {10'h010 + 10'(i), word[31-8*i -: 8]});

      e0 = n_en_rise;
      issue(1'b0, 1'b1, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 9);
      wait_idle();
      check("wl_enables", n_en_rise - e0, 4);

      issue(1'b0, 1'b0, 10'h011, 32'h0, 32'h000000AD, 1'b0, 3);
      wait_idle();

      // Byte store at the top address uses only wdata[7:0]
      wlog.delete();
      issue(1'b1, 1'b0, 10'h3FF, 32'hFFFFFF5A, 32'h0, 1'b0, 3);
      wait_idle();
      check("bs_nwrites", wlog.size(), 1);
      if (wlog.size() > 0) check("bs_byte", wlog[0], {10'h3FF, 8'h5A});
      issue(1'b0, 1'b0, 10'h3FF, 32'h0, 32'h0000005A, 1'b0, 3);
      wait_idle();
      issue(1'b0, 1'b1, 10'h3FC, 32'h0, 32'h1122335A, 1'b0, 9);
      wait_idle();

      // Misaligned word accesses: no memory activity, rdata preserved
      e0 = n_en_rise;
      issue(1'b0, 1'b1, 10'h013, 32'h0, 32'h0, 1'b1, 1);
      wait_idle();
      issue(1'b1, 1'b1, 10'h002, 32'h12345678, 32'h0, 1'b1, 1);
      wait_idle();
      check("mis_enables", n_en_rise - e0, 0);

      // req_valid held high with a changing address while busy
      e0 = n_en_rise;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 1'b1;
      bus.req_addr  = 10'h010;
      sb.push_back('{32'hDEADBEEF, 1'b0, 9});
      last_rdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.resp_valid) break;
         check("busy_ready", bus.req_ready, 0);
         bus.req_addr  = 10'h3FC;
         bus.req_write = 1'(i % 2);
         bus.req_wdata = $urandom;
      end
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      wait_idle();
      check("hold_enables", n_en_rise - e0, 4);

      // Reset during the third byte of a word load
      issue(1'b0, 1'b1, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 9);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.mem_enable && bus.mem_address == 10'h012) found = 1'b1;
      end
      check("rst_reach_byte2", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_enable", bus.mem_enable, 0);
      check("arst_ready", bus.req_ready, 1);
      check("arst_valid", bus.resp_valid, 0);
      check("arst_rdata", bus.resp_rdata, 0);
      sb.delete();
      last_rdata = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 1'b1, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 9);
      wait_idle();
      issue(1'b0, 1'b0, 10'h3FD, 32'h0, 32'h00000022, 1'b0, 3);
      wait_idle();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
